// File: rtl/ysyx_2022040010_dcache_data_nway_if.sv
// Bus bundle between the D-cache controller/AXI bridge and the data array.
// Core word port, refill beat channel and writeback beat channel.
interface ysyx_2022040010_dcache_data_nway_if #(
    parameter int WAYS      = 2,
    parameter int SETS      = 64,
    parameter int LINE_BITS = 128,
    parameter int WORD_BITS = 64,
    parameter int BEAT_BITS = 64
);
    localparam int IW  = $clog2(SETS);
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int NW  = LINE_BITS / WORD_BITS;
    localparam int NWW = (NW > 1) ? $clog2(NW) : 1;
    localparam int SB  = WORD_BITS / 8;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [SB-1:0]        req_sel;
    logic [IW-1:0]        req_index;
    logic [NWW-1:0]       req_word;
    logic [WORD_BITS-1:0] req_wdata;
    logic [WAYS-1:0]      hit_way;
    logic                 rsp_valid;
    logic [WORD_BITS-1:0] rsp_rdata;
    logic                 refill_start;
    logic                 wb_start;
    logic [IW-1:0]        xfer_index;
    logic [WW-1:0]        xfer_way;
    logic                 rf_valid;
    logic [BEAT_BITS-1:0] rf_data;
    logic                 rf_ready;
    logic                 refill_done;
    logic                 wb_valid;
    logic [BEAT_BITS-1:0] wb_data;
    logic                 wb_last;
    logic                 wb_ready;
    logic                 wb_done;
    logic                 busy;

    modport master (
        output req_valid, req_we, req_sel, req_index, req_word,
        output req_wdata, hit_way, refill_start, wb_start,
        output xfer_index, xfer_way, rf_valid, rf_data, wb_ready,
        input  req_ready, rsp_valid, rsp_rdata, rf_ready,
        input  refill_done, wb_valid, wb_data, wb_last,
        input  wb_done, busy
    );

    modport slave (
        input  req_valid, req_we, req_sel, req_index, req_word,
        input  req_wdata, hit_way, refill_start, wb_start,
        input  xfer_index, xfer_way, rf_valid, rf_data, wb_ready,
        output req_ready, rsp_valid, rsp_rdata, rf_ready,
        output refill_done, wb_valid, wb_data, wb_last,
        output wb_done, busy
    );
endinterface

// File: rtl/ysyx_2022040010_dcache_data_nway.sv
// N-way D-cache data array: byte-masked word loads/stores plus
// beat-wise line refill and writeback engines toward the bus bridge.
module ysyx_2022040010_dcache_data_nway #(
    parameter int WAYS      = 2,
    parameter int SETS      = 64,
    parameter int LINE_BITS = 128,
    parameter int WORD_BITS = 64,
    parameter int BEAT_BITS = 64
) (
    input  logic clk,
    input  logic rst,
    ysyx_2022040010_dcache_data_nway_if.slave bus
);
    localparam int IW  = $clog2(SETS);
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int NW  = LINE_BITS / WORD_BITS;
    localparam int NWW = (NW > 1) ? $clog2(NW) : 1;
    localparam int NB  = LINE_BITS / BEAT_BITS;
    localparam int CW  = $clog2(NB) + 1;
    localparam int SB  = WORD_BITS / 8;

    typedef enum logic [2:0] {
        IDLE, REFILL, WB_RD, WB_LD, WB_SEND
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        xidx_q;
    logic [WW-1:0]        xway_q;
    logic [LINE_BITS-1:0] buf_q, buf_d;
    logic [LINE_BITS-1:0] rdline_q, shift_q;
    logic [LINE_BITS-1:0] mem_q [WAYS][SETS];
    logic                 rsp_valid_q;
    logic [WORD_BITS-1:0] rsp_rdata_q;
    logic                 refill_done_q, wb_done_q;
    logic                 accept, refill_wr, wb_fire, wb_end, xstart;
    logic [WW-1:0]        way_sel;
    logic                 hit;
    logic [LINE_BITS-1:0] cur_line, st_line;
    logic [WORD_BITS-1:0] ld_word;

    // Lowest set bit of the hit vector picks the way.
    always_comb begin
        way_sel = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (bus.hit_way[i]) way_sel = WW'(i);
        end
    end

    assign hit = |bus.hit_way;

    // Word extract for loads and byte-merged line for stores.
    always_comb begin
        cur_line = mem_q[way_sel][bus.req_index];
        st_line  = cur_line;
        ld_word  = '0;
        for (int w = 0; w < NW; w++) begin
            if (bus.req_word == NWW'(w)) begin
                ld_word = cur_line[w*WORD_BITS +: WORD_BITS];
                for (int b = 0; b < SB; b++) begin
                    if (bus.req_sel[b])
                        st_line[w*WORD_BITS + b*8 +: 8] =
                            bus.req_wdata[b*8 +: 8];
                end
            end
        end
    end

    // FSM next state, handshake outputs and refill line assembly.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        accept       = 1'b0;
        refill_wr    = 1'b0;
        wb_fire      = 1'b0;
        wb_end       = 1'b0;
        xstart       = 1'b0;
        bus.rf_ready = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.wb_start) begin
                    state_d = WB_RD;
                    cnt_d   = '0;
                    xstart  = 1'b1;
                end else if (bus.refill_start) begin
                    state_d = REFILL;
                    cnt_d   = '0;
                    xstart  = 1'b1;
                end else begin
                    accept = bus.req_valid;
                end
            end
            REFILL: begin
                bus.rf_ready = 1'b1;
                if (bus.rf_valid) begin
                    for (int b = 0; b < NB; b++) begin
                        if (cnt_q == CW'(b))
                            buf_d[b*BEAT_BITS +: BEAT_BITS] = bus.rf_data;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(NB - 1)) begin
                        refill_wr = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WB_RD: state_d = WB_LD;
            WB_LD: begin
                state_d = WB_SEND;
                cnt_d   = '0;
            end
            WB_SEND: begin
                bus.wb_valid = 1'b1;
                bus.wb_last  = (cnt_q == CW'(NB - 1));
                if (bus.wb_ready) begin
                    wb_fire = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (bus.wb_last) begin
                        wb_end  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.refill_done = refill_done_q;
    assign bus.wb_done     = wb_done_q;
    assign bus.wb_data     = shift_q[BEAT_BITS-1:0];

    // State and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Transfer target, line buffers, load response and done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            xidx_q        <= '0;
            xway_q        <= '0;
            buf_q         <= '0;
            rdline_q      <= '0;
            shift_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            refill_done_q <= 1'b0;
            wb_done_q     <= 1'b0;
        end else begin
            if (xstart) begin
                xidx_q <= bus.xfer_index;
                xway_q <= bus.xfer_way;
            end
            buf_q <= buf_d;
            if (state_q == WB_RD) rdline_q <= mem_q[xway_q][xidx_q];
            if (state_q == WB_LD) shift_q <= rdline_q;
            else if (wb_fire) shift_q <= shift_q >> BEAT_BITS;
            rsp_valid_q <= accept && !bus.req_we;
            if (accept && !bus.req_we)
                rsp_rdata_q <= hit ? ld_word : '0;
            refill_done_q <= refill_wr;
            wb_done_q     <= wb_end;
        end
    end

    // Storage array: refill writes a full line, stores merge bytes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (refill_wr)
                mem_q[xway_q][xidx_q] <= buf_d;
            else if (accept && bus.req_we && hit)
                mem_q[way_sel][bus.req_index] <= st_line;
        end
    end
endmodule

// File: doc/ysyx_2022040010_dcache_data_nway.md
# ysyx_2022040010_dcache_data_nway

Parametrised N-way D-cache data array with byte-masked core word access and multi-beat refill/writeback engines. Sits between the D-cache controller (which owns tags, LRU and hit detection) and the AXI bridge. Replaces the fixed 2-way/128-bit array. Lines are moved to and from the bus as BEAT_BITS beats under valid/ready handshakes, not as single-cycle whole-line transfers.

## Interface
- WAYS, 2, number of ways; power of 2, 1..8
- SETS, 64, lines per way; power of 2
- LINE_BITS, 128, line width
- WORD_BITS, 64, core access width
- BEAT_BITS, 64, bus beat width; divides LINE_BITS
- Derived: IW=log2(SETS), WW=log2(WAYS) (min 1), NW=LINE_BITS/WORD_BITS, NB=LINE_BITS/BEAT_BITS
- clk in 1: clock
- rst in 1: reset, synchronous, active-high
- req_valid in 1: core access request
- req_ready out 1: high only in IDLE
- req_we in 1: 1=store, 0=load
- req_sel in WORD_BITS/8: store byte enables
- req_index in IW: set index
- req_word in log2(NW) (min 1): word within line
- req_wdata in WORD_BITS: store data
- hit_way in WAYS: one-hot hit vector from tag compare
- rsp_valid out 1: load data valid
- rsp_rdata out WORD_BITS: load data
- refill_start in 1: begin refill of (xfer_index, xfer_way)
- wb_start in 1: begin writeback of (xfer_index, xfer_way)
- xfer_index in IW; xfer_way in WW: target set and way, sampled at start
- rf_valid in 1; rf_data in BEAT_BITS; rf_ready out 1: refill beat channel
- refill_done out 1: one-cycle pulse
- wb_valid out 1; wb_data out BEAT_BITS; wb_last out 1; wb_ready in 1: writeback beat channel
- wb_done out 1: one-cycle pulse
- busy out 1: state != IDLE

## Operation
- Storage: WAYS×SETS×LINE_BITS register array, not reset. Array reads are registered, with 1-cycle latency.
- FSM states: IDLE, REFILL, WB_RD, WB_LD, WB_SEND.
- IDLE, core request:
  - Accepted when req_valid && no start is asserted.
  - Way = lowest set bit of hit_way.
  - Load: rsp_valid=1 the next cycle. rsp_rdata = selected word of that way/line, or 0 if hit_way==0.
  - Store with hit: only bytes with req_sel=1 are written in the selected word. hit_way==0 is a no-op.
  - A store does not raise rsp_valid.
- Start priority in IDLE: wb_start > refill_start > core request. Losing inputs are dropped, and the controller re-issues them. Starts outside IDLE are ignored.
- REFILL:
  - rf_ready=1. Each rf_valid&&rf_ready beat is stored into the line buffer at beat_cnt (beat 0 = bits [BEAT_BITS-1:0]), and beat_cnt increments.
  - On beat NB-1, the whole line {beat, buffer} is written to the target way/set in the same edge.
  - Next cycle: refill_done=1, IDLE.
- WB_RD: issue array read of the target, then go to WB_LD.
- WB_LD: latch the line into the shift register, then go to WB_SEND with beat_cnt=0.
- WB_SEND:
  - wb_valid=1, wb_data = shift_reg[BEAT_BITS-1:0], wb_last = (beat_cnt==NB-1).
  - On handshake: shift right by BEAT_BITS and increment beat_cnt.
  - On the last handshake: go to IDLE, wb_done=1 next cycle.
  - wb_valid/wb_data stay stable while wb_ready=0.
- beat_cnt width is log2(NB)+1. It never wraps within a burst and clears on entering REFILL/WB_RD.
- Reset mid-burst: FSM goes to IDLE, beat_cnt=0, partial refill is discarded (array untouched), and the writeback stream is abandoned.

## Timing
- Reset values: req_ready=1 after reset deasserts. rsp_valid, rsp_rdata, rf_ready, refill_done, wb_valid, wb_data, wb_last, wb_done and busy are all 0.
- Load latency: 1 cycle from acceptance to rsp_valid.
- Store in cycle N, load of the same word in N+1: returns the merged data (write precedes registered read).
- Refill: minimum NB cycles of beats plus 1 cycle (done); busy from the cycle after start.
- Writeback:
  - wb_start at N → first wb_valid at N+3.
  - With wb_ready held high: last beat at N+2+NB, wb_done at N+3+NB.
- rsp_rdata holds its last value when rsp_valid=0. rsp_rdata is 0 after a miss load.

## Test plan
- Refill set 5 way 1 with beats 0x1111_2222_3333_4444 and 0xAAAA_BBBB_CCCC_DDDD → refill_done 1 cycle after beat 1. Then load idx 5, word 1, hit_way=2'b10 → rsp_rdata=0xAAAA_BBBB_CCCC_DDDD one cycle later.
- Store idx 5, word 0, sel=8'h0F, wdata=0xFFFF_FFFF_0000_0000, hit 2'b10; load next cycle → 0x1111_2222_0000_0000. Way 0 of set 5 is unchanged.
- Writeback idx 5, way 1 with wb_ready toggling 1,0,1 → beats 0x1111_2222_0000_0000 then 0xAAAA_BBBB_CCCC_DDDD. wb_data is stable during the stall, wb_last is on the second beat only, and wb_done follows.
- Same cycle wb_start, refill_start and req_valid in IDLE → writeback runs, no refill beats are accepted (rf_ready=0), and the request is not accepted.
- Load with hit_way=0 → rsp_valid=1, rsp_rdata=0. Load with hit_way=2'b11 → way-0 data.
- rst asserted after 1 of 2 refill beats, then a load of the target → old line contents. busy=0 and rf_ready=0 the cycle after reset.
